// File: rtl/hier_fanout_pkg.sv
// -----------------------------------------------------------------------------
// hier_fanout_pkg
// Shared types and helpers for the hier_fanout_node hierarchy node.
//   state_t : node controller states (broadcast states only with
//             HIER_FANOUT_BCAST_EN defined)
//   idx_w() : width of a child index, clog2(NUM_CHILDREN), minimum 1
// -----------------------------------------------------------------------------
package hier_fanout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
`ifdef HIER_FANOUT_BCAST_EN
        ST_ISSUE    = 2'd1,
        ST_BCAST    = 2'd2,
        ST_WAIT_ALL = 2'd3
`else
        ST_ISSUE    = 2'd1
`endif
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hier_fanout_rr_pick.sv
// -----------------------------------------------------------------------------
// hier_fanout_rr_pick
// Combinational rotating-priority finder: returns the first non-busy child at
// or after i_ptr, searching upward with wrap-around.
//   i_busy  [NUM_CHILDREN] : busy map, 1 = child occupied
//   i_ptr   [IDX_W]        : search start index (0..NUM_CHILDREN-1)
//   o_idx   [IDX_W]        : selected child index (0 when none found)
//   o_found                : at least one child is idle
// -----------------------------------------------------------------------------
module hier_fanout_rr_pick
    import hier_fanout_pkg::*;
#(
    parameter int NUM_CHILDREN = 10,
    localparam int IDX_W       = idx_w(NUM_CHILDREN)
) (
    input  logic [NUM_CHILDREN-1:0] i_busy,
    input  logic [IDX_W-1:0]        i_ptr,
    output logic [IDX_W-1:0]        o_idx,
    output logic                    o_found
);

    int w_pos;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it holding its old value (no latch).
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_CHILDREN) w_pos = w_pos - NUM_CHILDREN;
            if (!o_found && !i_busy[w_pos]) begin
                o_idx   = IDX_W'(w_pos);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hier_fanout_node.sv
// -----------------------------------------------------------------------------
// hier_fanout_node
// Generic fan-out node: takes tokens from one valid/ready upstream port and
// dispatches each to an idle child slot chosen by a rotating pointer. Tracks a
// per-child busy map, counts completions and flags completions from idle
// children (sticky err).
// Optional feature macro: HIER_FANOUT_BCAST_EN -- adds in_bcast; a broadcast
// token goes to every child and bcast_done pulses once all have completed.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   in_valid/in_ready/in_data: upstream token port
//   in_bcast                 : broadcast request (macro only)
//   ch_valid/ch_ready        : per-child handshake, ch_data shared payload
//   ch_done                  : per-child single-cycle completion pulse
//   busy, cmp_cnt, err       : busy map, completion count (wraps), sticky error
//   bcast_done               : broadcast joint-completion pulse (0 without macro)
// -----------------------------------------------------------------------------
module hier_fanout_node
    import hier_fanout_pkg::*;
#(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 8,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
`ifdef HIER_FANOUT_BCAST_EN
    input  logic                    in_bcast,
`endif
    output logic [NUM_CHILDREN-1:0] ch_valid,
    input  logic [NUM_CHILDREN-1:0] ch_ready,
    output logic [DATA_W-1:0]       ch_data,
    input  logic [NUM_CHILDREN-1:0] ch_done,
    output logic [NUM_CHILDREN-1:0] busy,
    output logic [CNT_W-1:0]        cmp_cnt,
    output logic                    bcast_done,
    output logic                    err
);

    localparam int IDX_W = idx_w(NUM_CHILDREN);
    localparam logic [NUM_CHILDREN-1:0] ONE_HOT0 = NUM_CHILDREN'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_target;
    logic [DATA_W-1:0]       r_data;
    logic [NUM_CHILDREN-1:0] r_busy;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;

    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_pick_found;
    logic [NUM_CHILDREN-1:0] w_tgt_oh;
    logic [NUM_CHILDREN-1:0] w_busy_set;
    logic [NUM_CHILDREN-1:0] w_done_ok;
    logic                    w_done_bad;
    logic [CNT_W-1:0]        w_done_inc;
    logic                    w_accept;
    logic                    w_issue_hs;

`ifdef HIER_FANOUT_BCAST_EN
    logic [NUM_CHILDREN-1:0] r_hs;      // children already handshaken in BCAST
    logic [NUM_CHILDREN-1:0] w_hs_nxt;
    logic                    r_bcast_done;
    logic                    w_bcast_fin;
`endif

    hier_fanout_rr_pick #(
        .NUM_CHILDREN (NUM_CHILDREN)
    ) u_pick (
        .i_busy  (r_busy),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_tgt_oh = ONE_HOT0 << r_target;

    // Completions are judged against the registered busy map, so a done in
    // the same cycle as that child's handshake counts as an error.
    assign w_done_ok  = ch_done & r_busy;
    assign w_done_bad = |(ch_done & ~r_busy);

    always_comb begin
        w_done_inc = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            w_done_inc = w_done_inc + CNT_W'(w_done_ok[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        ch_valid    = '0;
        w_busy_set  = '0;
        w_accept    = 1'b0;
        w_issue_hs  = 1'b0;
`ifdef HIER_FANOUT_BCAST_EN
        w_hs_nxt    = r_hs;
        w_bcast_fin = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                in_ready = w_pick_found;
`ifdef HIER_FANOUT_BCAST_EN
                if (in_bcast) in_ready = (r_busy == '0);
`endif
                if (in_valid && in_ready) begin
                    w_accept = 1'b1;
`ifdef HIER_FANOUT_BCAST_EN
                    w_state_nxt = in_bcast ? ST_BCAST : ST_ISSUE;
`else
                    w_state_nxt = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                ch_valid = w_tgt_oh;
                if (|(ch_ready & w_tgt_oh)) begin
                    w_busy_set  = w_tgt_oh;
                    w_issue_hs  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef HIER_FANOUT_BCAST_EN
            ST_BCAST: begin
                ch_valid   = ~r_hs;
                w_busy_set = ch_ready & ~r_hs;
                w_hs_nxt   = r_hs | w_busy_set;
                if (&w_hs_nxt) begin
                    w_hs_nxt    = '0;
                    w_state_nxt = ST_WAIT_ALL;
                end
            end
            ST_WAIT_ALL: begin
                if (r_busy == '0) begin
                    w_bcast_fin = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_target <= '0;
            r_data   <= '0;
            r_busy   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (r_busy & ~w_done_ok) | w_busy_set;
            r_cnt   <= r_cnt + w_done_inc;
            if (w_done_bad) r_err <= 1'b1;
            if (w_accept) begin
                r_data   <= in_data;
                r_target <= w_pick_idx;
            end
            if (w_issue_hs) begin
                r_ptr <= (r_target == IDX_W'(NUM_CHILDREN - 1)) ? '0 : r_target + 1'b1;
            end
        end
    end

`ifdef HIER_FANOUT_BCAST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs         <= '0;
            r_bcast_done <= 1'b0;
        end else begin
            r_hs         <= w_hs_nxt;
            r_bcast_done <= w_bcast_fin;
        end
    end
    assign bcast_done = r_bcast_done;
`else
    assign bcast_done = 1'b0;
`endif

    assign ch_data = r_data;
    assign busy    = r_busy;
    assign cmp_cnt = r_cnt;
    assign err     = r_err;

endmodule
